// File: rtl/cache_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_arbiter_if
//   Bundles the I-cache, D-cache and physical-memory line ports seen by
//   cache_arbiter.
//
//   Modports:
//     slave  - the arbiter's view: client requests and memory completion are
//              inputs; fill lines, resp pulses and pmem strobes are outputs.
//     master - the environment's view (caches + memory), the mirror image.
//
//   Signals:
//     icache_read/address         I-cache fill request (level) and address
//     icache_rdata/resp           fill line and one-cycle completion pulse
//     dcache_read/write/address   D-cache fill / write-back request and address
//     dcache_wdata                write-back line
//     dcache_rdata/resp           fill line and one-cycle completion pulse
//     pmem_read/write/address     registered memory strobes and line address
//     pmem_wdata                  registered write-back line
//     pmem_rdata/resp             memory read line and completion pulse
// -----------------------------------------------------------------------------
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_address;
  logic [LINE_WIDTH-1:0] icache_rdata;
  logic                  icache_resp;

  logic                  dcache_read;
  logic                  dcache_write;
  logic [ADDR_WIDTH-1:0] dcache_address;
  logic [LINE_WIDTH-1:0] dcache_wdata;
  logic [LINE_WIDTH-1:0] dcache_rdata;
  logic                  dcache_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//   Arbitrates the I-cache and D-cache line ports onto one physical-memory
//   port. One line transaction at a time: a fill for either cache, or a
//   write-back from the D-cache. The winning request is captured into
//   registers that drive memory directly, so the pmem outputs have no
//   combinational path from the client inputs. The fill line and a one-cycle
//   resp pulse go back only to the granted client.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      cache_arbiter_if.slave (client and memory line ports)
//
//   Build option:
//     CACHE_ARBITER_RR_EN  when defined, simultaneous requests alternate by a
//                          last-grant register (reset to D-cache); otherwise
//                          the D-cache always wins a tie.
// -----------------------------------------------------------------------------
module cache_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  // Memory only ever sees line-aligned addresses.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    return a & LINE_MASK;
  endfunction

  state_t state;
  logic   owner_d;     // 1: transaction belongs to the D-cache
`ifdef CACHE_ARBITER_RR_EN
  logic   last_d;      // 1: last grant went to the D-cache
`endif

  logic i_req;
  logic d_req;
  logic grant_d;

  // Winner selection for the IDLE edge. Only consulted in IDLE, so request
  // changes during an access never disturb the registered memory request.
  always_comb begin
    i_req = bus.icache_read;
    d_req = bus.dcache_read | bus.dcache_write;
`ifdef CACHE_ARBITER_RR_EN
    // On a tie the client that did not win last time goes first.
    grant_d = d_req && (!i_req || !last_d);
`else
    grant_d = d_req;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      owner_d          <= 1'b1;
`ifdef CACHE_ARBITER_RR_EN
      last_d           <= 1'b1;
`endif
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
      bus.pmem_wdata   <= '0;
      bus.icache_rdata <= '0;
      bus.icache_resp  <= 1'b0;
      bus.dcache_rdata <= '0;
      bus.dcache_resp  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.icache_resp <= 1'b0;
          bus.dcache_resp <= 1'b0;
          if (grant_d) begin
            owner_d          <= 1'b1;
`ifdef CACHE_ARBITER_RR_EN
            last_d           <= 1'b1;
`endif
            bus.pmem_address <= line_align(bus.dcache_address);
            // Read and write together is a write-back; the fill follows
            // as a separate request once the victim is out.
            if (bus.dcache_write) begin
              bus.pmem_write <= 1'b1;
              bus.pmem_wdata <= bus.dcache_wdata;
            end else begin
              bus.pmem_read  <= 1'b1;
            end
            state <= D_ACC;
          end else if (i_req) begin
            owner_d          <= 1'b0;
`ifdef CACHE_ARBITER_RR_EN
            last_d           <= 1'b0;
`endif
            bus.pmem_address <= line_align(bus.icache_address);
            bus.pmem_read    <= 1'b1;
            state            <= I_ACC;
          end
        end

        I_ACC, D_ACC: begin
          if (bus.pmem_resp) begin
            if (bus.pmem_read) begin
              if (owner_d) bus.dcache_rdata <= bus.pmem_rdata;
              else         bus.icache_rdata <= bus.pmem_rdata;
            end
            if (owner_d) bus.dcache_resp <= 1'b1;
            else         bus.icache_resp <= 1'b1;
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
            state          <= RESP;
          end
        end

        RESP: begin
          // The client drops its request during this cycle, so returning to
          // IDLE cannot re-grant the request just completed.
          bus.icache_resp <= 1'b0;
          bus.dcache_resp <= 1'b0;
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
//   Directed bench for cache_arbiter. Inputs change on the falling edge and
//   outputs are sampled on the falling edge, half a cycle after the active
//   edge. The memory side is driven by hand in each scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_arbiter;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  cache_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

  cache_arbiter #(
    .ADDR_WIDTH (16),
    .LINE_WIDTH (128),
    .OFFSET_BITS(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_WB = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] LINE_D1 = 128'hD1D1_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] LINE_5A = {16{8'h5A}};
  localparam logic [127:0] LINE_JK = {8{16'hDEAD}};

  task automatic idle_inputs();
    bus.icache_read    = 1'b0;
    bus.icache_address = '0;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.pmem_read, bus.pmem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 0000",
               {bus.pmem_read, bus.pmem_write, bus.icache_resp, bus.dcache_resp});
    end
    vectors++;
    if (bus.pmem_address !== 16'h0 || bus.pmem_wdata !== 128'h0 ||
        bus.icache_rdata !== 128'h0 || bus.dcache_rdata !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: addr %h wdata %h irdata %h drdata %h want all 0",
               bus.pmem_address, bus.pmem_wdata, bus.icache_rdata, bus.dcache_rdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_icache_read();
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h1234;
    @(negedge clk);
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h1230) begin
      miscompares++;
      $display("FAIL iread_grant: rd %b wr %b addr %h want 1 0 1230",
               bus.pmem_read, bus.pmem_write, bus.pmem_address);
    end
    // memory answers on the fourth cycle of the access
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h1230 ||
          bus.icache_resp !== 1'b0 || bus.dcache_resp !== 1'b0) begin
        miscompares++;
        $display("FAIL iread_hold: cyc %0d rd %b addr %h iresp %b dresp %b want 1 1230 0 0",
                 i, bus.pmem_read, bus.pmem_address, bus.icache_resp, bus.dcache_resp);
      end
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_A5;
    @(negedge clk);
    bus.pmem_resp   = 1'b0;
    bus.pmem_rdata  = LINE_JK;
    vectors++;
    if (bus.icache_resp !== 1'b1 || bus.icache_rdata !== LINE_A5 ||
        bus.pmem_read !== 1'b0 || bus.dcache_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL iread_resp: iresp %b rdata %h rd %b dresp %b want 1 %h 0 0",
               bus.icache_resp, bus.icache_rdata, bus.pmem_read, bus.dcache_resp, LINE_A5);
    end
    vectors++;
    if (bus.dcache_rdata !== 128'h0) begin
      miscompares++;
      $display("FAIL iread_dcache_untouched: drdata %h want 0", bus.dcache_rdata);
    end
    bus.icache_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.icache_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL iread_pulse_width: iresp %b rd %b want 0 0", bus.icache_resp, bus.pmem_read);
    end
    @(negedge clk);
  endtask

  task automatic test_dcache_write();
    bus.dcache_write   = 1'b1;
    bus.dcache_address = 16'h8008;
    bus.dcache_wdata   = LINE_WB;
    @(negedge clk);
    vectors++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 ||
        bus.pmem_address !== 16'h8000 || bus.pmem_wdata !== LINE_WB) begin
      miscompares++;
      $display("FAIL dwrite_grant: wr %b rd %b addr %h wdata %h want 1 0 8000 %h",
               bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wdata, LINE_WB);
    end
    // client changes during the access must not leak through
    bus.dcache_address = 16'hFFF0;
    bus.dcache_wdata   = LINE_JK;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.pmem_write !== 1'b1 || bus.pmem_address !== 16'h8000 || bus.pmem_wdata !== LINE_WB) begin
        miscompares++;
        $display("FAIL dwrite_hold: cyc %0d wr %b addr %h wdata %h want 1 8000 %h",
                 i, bus.pmem_write, bus.pmem_address, bus.pmem_wdata, LINE_WB);
      end
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_JK;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    vectors++;
    if (bus.dcache_resp !== 1'b1 || bus.dcache_rdata !== 128'h0 ||
        bus.pmem_write !== 1'b0 || bus.icache_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL dwrite_resp: dresp %b drdata %h wr %b iresp %b want 1 0 0 0",
               bus.dcache_resp, bus.dcache_rdata, bus.pmem_write, bus.icache_resp);
    end
    bus.dcache_write = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.dcache_resp !== 1'b0 || bus.pmem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL dwrite_pulse_width: dresp %b wr %b want 0 0", bus.dcache_resp, bus.pmem_write);
    end
    @(negedge clk);
  endtask

  task automatic test_both_clients();
    logic [15:0]  first_addr;
    logic [15:0]  second_addr;
    logic         first_is_d;
`ifdef CACHE_ARBITER_RR_EN
    // last grant was the D-cache write-back, so the I-cache wins the tie
    first_addr  = 16'h0100;
    second_addr = 16'h0200;
    first_is_d  = 1'b0;
`else
    first_addr  = 16'h0200;
    second_addr = 16'h0100;
    first_is_d  = 1'b1;
`endif
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h0100;
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 16'h0200;
    @(negedge clk);
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== first_addr) begin
      miscompares++;
      $display("FAIL both_first_grant: rd %b addr %h want 1 %h", bus.pmem_read, bus.pmem_address, first_addr);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = first_is_d ? LINE_D1 : LINE_5A;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    vectors++;
    if (bus.dcache_resp !== first_is_d || bus.icache_resp !== !first_is_d) begin
      miscompares++;
      $display("FAIL both_first_resp: dresp %b iresp %b want %b %b",
               bus.dcache_resp, bus.icache_resp, first_is_d, !first_is_d);
    end
    if (first_is_d) bus.dcache_read = 1'b0;
    else            bus.icache_read = 1'b0;
    @(negedge clk);   // RESP -> IDLE
    @(negedge clk);   // IDLE grants the remaining client
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== second_addr) begin
      miscompares++;
      $display("FAIL both_second_grant: rd %b addr %h want 1 %h", bus.pmem_read, bus.pmem_address, second_addr);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = first_is_d ? LINE_5A : LINE_D1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    vectors++;
    if (bus.dcache_resp !== !first_is_d || bus.icache_resp !== first_is_d) begin
      miscompares++;
      $display("FAIL both_second_resp: dresp %b iresp %b want %b %b",
               bus.dcache_resp, bus.icache_resp, !first_is_d, first_is_d);
    end
    bus.icache_read = 1'b0;
    bus.dcache_read = 1'b0;
    vectors++;
    if (bus.dcache_rdata !== LINE_D1 || bus.icache_rdata !== LINE_5A) begin
      miscompares++;
      $display("FAIL both_rdata: drdata %h irdata %h want %h %h",
               bus.dcache_rdata, bus.icache_rdata, LINE_D1, LINE_5A);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_write_together();
    bus.dcache_read    = 1'b1;
    bus.dcache_write   = 1'b1;
    bus.dcache_address = 16'h3C7F;
    bus.dcache_wdata   = LINE_5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b1 || bus.pmem_address !== 16'h3C70) begin
        miscompares++;
        $display("FAIL rw_writeback: cyc %0d rd %b wr %b addr %h want 0 1 3c70",
                 i, bus.pmem_read, bus.pmem_write, bus.pmem_address);
      end
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_JK;
    @(negedge clk);
    bus.pmem_resp    = 1'b0;
    bus.dcache_read  = 1'b0;
    bus.dcache_write = 1'b0;
    vectors++;
    if (bus.dcache_resp !== 1'b1 || bus.pmem_read !== 1'b0 || bus.dcache_rdata !== LINE_D1) begin
      miscompares++;
      $display("FAIL rw_resp: dresp %b rd %b drdata %h want 1 0 %h",
               bus.dcache_resp, bus.pmem_read, bus.dcache_rdata, LINE_D1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stray_resp();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_JK;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({bus.icache_resp, bus.dcache_resp, bus.pmem_read, bus.pmem_write} !== 4'b0000 ||
          bus.icache_rdata !== LINE_5A || bus.dcache_rdata !== LINE_D1) begin
        miscompares++;
        $display("FAIL stray_resp: cyc %0d iresp %b dresp %b rd %b wr %b want 0000 and rdata held",
                 i, bus.icache_resp, bus.dcache_resp, bus.pmem_read, bus.pmem_write);
      end
      @(negedge clk);
    end
    // still in IDLE: a fresh request is granted with the usual latency
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h0ABC;
    @(negedge clk);
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0AB0) begin
      miscompares++;
      $display("FAIL stray_then_grant: rd %b addr %h want 1 0ab0", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_A5;
    @(negedge clk);
    bus.pmem_resp   = 1'b0;
    bus.icache_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 16'h4444;
    @(negedge clk);
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h4440) begin
      miscompares++;
      $display("FAIL areset_grant: rd %b addr %h want 1 4440", bus.pmem_read, bus.pmem_address);
    end
    @(negedge clk);
    #2;
    reset_n         = 1'b0;
    bus.dcache_read = 1'b0;
    #1;
    vectors++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'h0) begin
      miscompares++;
      $display("FAIL areset_async_drop: rd %b addr %h want 0 0", bus.pmem_read, bus.pmem_address);
    end
    // the abandoned memory reply arrives while reset is held
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_JK;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    vectors++;
    if (bus.dcache_resp !== 1'b0 || bus.icache_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_no_resp: dresp %b iresp %b want 0 0", bus.dcache_resp, bus.icache_resp);
    end
    reset_n = 1'b1;
    @(negedge clk);
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h2222;
    @(negedge clk);
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h2220) begin
      miscompares++;
      $display("FAIL areset_regrant: rd %b addr %h want 1 2220", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_5A;
    @(negedge clk);
    bus.pmem_resp   = 1'b0;
    bus.icache_read = 1'b0;
    vectors++;
    if (bus.icache_resp !== 1'b1 || bus.icache_rdata !== LINE_5A || bus.dcache_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_regrant_resp: iresp %b irdata %h dresp %b want 1 %h 0",
               bus.icache_resp, bus.icache_rdata, bus.dcache_resp, LINE_5A);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_both_clients();
    test_read_write_together();
    test_stray_resp();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
